global_reset_ctrl: RTL and testbench

- Design-wide reset manager for the 48 MHz USB domain.
- Combines the asynchronous system reset with the PLL lock indication. Produces an active-high reset, `rst`, that asserts asynchronously and releases synchronously.
- `rst` releases only after lock is synchronized, filtered and stable for a programmable hold time.
- Sits between the PLL and all 48 MHz logic, such as the USB serial core and LED counter.

---
 rtl/global_reset_ctrl.sv | 145 ++++++++++++++
 tb/tb_global_reset_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/global_reset_ctrl.sv
// Reset manager for the 48 MHz domain.
// Combines the asynchronous system reset with the PLL lock indication and
// produces a design reset that asserts immediately and releases only after
// lock has been synchronized, filtered and held stable for a while.
module global_reset_ctrl #(
   parameter int SYNC_STAGES = 2,   // flops synchronizing rst_in, >= 2
   parameter int LOCK_FILTER = 4,   // consecutive lock-high cycles before stretch, >= 1
   parameter int HOLD_CYCLES = 16   // further lock-high cycles before release, >= 1
) (
   input  logic       clk_48mhz,
   input  logic       reset,
   input  logic       rst_in,
   output logic       rst,
   output logic       rst_n,
   output logic       release_pulse,
   output logic [7:0] lock_lost_count
);

   // Counter widths sized to hold LOCK_FILTER-1 / HOLD_CYCLES-1 (minimum one bit).
   localparam int FW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [FW-1:0] FCNT_LAST = FW'(LOCK_FILTER - 1);
   localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

   // One-hot state encoding.
   localparam logic [2:0] S_WAIT_LOCK = 3'b001;
   localparam logic [2:0] S_STRETCH   = 3'b010;
   localparam logic [2:0] S_RUN       = 3'b100;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   lock_s;
   logic [2:0]             state_reg;
   logic [2:0]             state_next;
   logic [FW-1:0]          fcnt_reg;
   logic [FW-1:0]          fcnt_next;
   logic [HW-1:0]          hcnt_reg;
   logic [HW-1:0]          hcnt_next;
   logic                   rst_reg;
   logic                   release_reg;
   logic [7:0]             lost_reg;
   logic                   enter_run;
   logic                   leave_run;

   // Lock synchronizer: shift rst_in through the chain, last stage is lock_s.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], rst_in};
      end
   end

   assign lock_s = sync_reg[SYNC_STAGES-1];

   // Next-state and counter logic: filter, then stretch, then run.
   always_comb begin
      state_next = state_reg;
      fcnt_next  = fcnt_reg;
      hcnt_next  = hcnt_reg;
      case (state_reg)
         S_WAIT_LOCK: begin
            if (!lock_s) begin
               fcnt_next = '0;
            end else if (fcnt_reg == FCNT_LAST) begin
               state_next = S_STRETCH;
               hcnt_next  = '0;
            end else begin
               fcnt_next = fcnt_reg + FW'(1);
            end
         end
         S_STRETCH: begin
            if (!lock_s) begin
               state_next = S_WAIT_LOCK;
               fcnt_next  = '0;
            end else if (hcnt_reg == HCNT_LAST) begin
               state_next = S_RUN;
            end else begin
               hcnt_next = hcnt_reg + HW'(1);
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_next = S_WAIT_LOCK;
               fcnt_next  = '0;
            end
         end
         default: begin
            // Any corrupted encoding falls back to waiting for lock.
            state_next = S_WAIT_LOCK;
            fcnt_next  = '0;
            hcnt_next  = '0;
         end
      endcase
   end

   assign enter_run = (state_next == S_RUN) && (state_reg != S_RUN);
   assign leave_run = (state_reg == S_RUN) && (state_next != S_RUN);

   // State and counter registers.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_reg <= S_WAIT_LOCK;
         fcnt_reg  <= '0;
         hcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         fcnt_reg  <= fcnt_next;
         hcnt_reg  <= hcnt_next;
      end
   end

   // Reset output flop: low exactly while the next state is RUN, so it clears
   // on the edge entering RUN and sets on the edge leaving it.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         rst_reg <= 1'b1;
      end else begin
         rst_reg <= (state_next != S_RUN);
      end
   end

   // One-cycle pulse registered on the edge that enters RUN.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         release_reg <= 1'b0;
      end else begin
         release_reg <= enter_run;
      end
   end

   // Saturating count of lock losses while running.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         lost_reg <= 8'd0;
      end else if (leave_run && (lost_reg != 8'hFF)) begin
         lost_reg <= lost_reg + 8'd1;
      end
   end

   assign rst             = rst_reg;
   assign rst_n           = ~rst_reg;
   assign release_pulse   = release_reg;
   assign lock_lost_count = lost_reg;

endmodule

// File: tb/tb_global_reset_ctrl.sv
// Self-checking bench for global_reset_ctrl.
// Reference model: lock is seen SYNC_STAGES edges after it is sampled; the
// design runs once LOCK_FILTER+HOLD_CYCLES consecutive lock-high cycles have
// been seen, and any seen lock-low drops it out (counted if it was running).
module tb_global_reset_ctrl;

   localparam int SYNC_STAGES = 2;
   localparam int LOCK_FILTER = 4;
   localparam int HOLD_CYCLES = 16;
   localparam int RUN_STREAK  = LOCK_FILTER + HOLD_CYCLES;
   localparam int LATENCY     = SYNC_STAGES + LOCK_FILTER + HOLD_CYCLES;

   logic       clk_48mhz;
   logic       reset;
   logic       rst_in;
   logic       rst;
   logic       rst_n;
   logic       release_pulse;
   logic [7:0] lock_lost_count;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // Reference model state
   logic sync_q[$];
   int   m_streak;
   bit   m_run;
   bit   m_pulse;
   int   m_cnt;

   global_reset_ctrl #(
      .SYNC_STAGES(SYNC_STAGES),
      .LOCK_FILTER(LOCK_FILTER),
      .HOLD_CYCLES(HOLD_CYCLES)
   ) dut (
      .clk_48mhz      (clk_48mhz),
      .reset          (reset),
      .rst_in         (rst_in),
      .rst            (rst),
      .rst_n          (rst_n),
      .release_pulse  (release_pulse),
      .lock_lost_count(lock_lost_count)
   );

   initial clk_48mhz = 1'b0;
   always #10 clk_48mhz = ~clk_48mhz;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task model_reset();
      sync_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) sync_q.push_back(1'b0);
      m_streak = 0;
      m_run    = 0;
      m_pulse  = 0;
      m_cnt    = 0;
   endtask

   task model_edge(input logic val);
      logic seen;
      sync_q.push_back(val);
      seen = sync_q.pop_front();
      m_pulse = 0;
      if (seen) begin
         if (m_streak < RUN_STREAK) m_streak++;
         if (!m_run && m_streak == RUN_STREAK) begin
            m_run   = 1;
            m_pulse = 1;
         end
      end else begin
         if (m_run && m_cnt < 255) m_cnt++;
         m_run    = 0;
         m_streak = 0;
      end
   endtask

   task compare_outputs();
      check_eq("rst", 32'(rst), 32'(!m_run));
      check_eq("rst_n", 32'(rst_n), 32'(m_run));
      check_eq("release_pulse", 32'(release_pulse), 32'(m_pulse));
      check_eq("lock_lost_count", 32'(lock_lost_count), 32'(m_cnt));
   endtask

   // One clock cycle: drive rst_in, take the edge, advance model, compare.
   task automatic step(input logic val);
      rst_in = val;
      @(posedge clk_48mhz);
      if (!reset) model_edge(val);
      #1;
      compare_outputs();
   endtask

   // Synchronous-looking reset window, released just after an edge.
   task automatic apply_reset(input logic val);
      reset = 1'b1;
      model_reset();
      repeat (5) step(val);
      reset = 1'b0;
   endtask

   // Asserts reset between edges and checks the immediate effect.
   task automatic async_reset_pulse();
      #4;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("async_rst", 32'(rst), 32'd1);
      check_eq("async_rst_n", 32'(rst_n), 32'd0);
      check_eq("async_count", 32'(lock_lost_count), 32'd0);
      check_eq("async_pulse", 32'(release_pulse), 32'd0);
      step(1'b1);
      step(1'b1);
      reset = 1'b0;
   endtask

   // Holds lock high and counts edges until the release pulse (bounded).
   task automatic wait_release(output int edges);
      edges = 0;
      do begin
         step(1'b1);
         edges++;
      end while (!release_pulse && edges < 200);
      check_eq("release_seen", 32'(release_pulse), 32'd1);
      check_eq("released_rst", 32'(rst), 32'd0);
   endtask

   initial begin
      int n;
      bit rst_low_seen;
      reset  = 1'b1;
      rst_in = 1'b0;
      model_reset();

      // Power-up with lock already present.
      apply_reset(1'b1);
      check_eq("reset_rst", 32'(rst), 32'd1);
      check_eq("reset_rst_n", 32'(rst_n), 32'd0);
      wait_release(n);
      check_eq("powerup_latency", 32'(n), 32'(LATENCY));
      step(1'b1);
      check_eq("pulse_one_cycle", 32'(release_pulse), 32'd0);
      check_eq("powerup_count", 32'(lock_lost_count), 32'd0);
      $display("powerup: release after %0d edges", n);

      // Lock arrives late.
      apply_reset(1'b0);
      rst_low_seen = 0;
      for (int i = 0; i < 50; i++) begin
         step(1'b0);
         if (!rst) rst_low_seen = 1;
      end
      check_eq("late_rst_held", 32'(rst_low_seen), 32'd0);
      wait_release(n);
      check_eq("late_latency", 32'(n), 32'(LATENCY));
      $display("lock late: release after %0d edges", n);

      // One-cycle lock glitch at edge 4 restarts filtering.
      apply_reset(1'b1);
      repeat (3) step(1'b1);
      step(1'b0);
      wait_release(n);
      check_eq("glitch_latency", 32'(n), 32'(LATENCY));
      $display("filter glitch: release %0d edges after glitch", n);

      // Lock loss while running.
      step(1'b0);
      step(1'b1);
      check_eq("loss_edge2_rst", 32'(rst), 32'd0);
      step(1'b1);
      check_eq("loss_edge3_rst", 32'(rst), 32'd1);
      check_eq("loss_count", 32'(lock_lost_count), 32'd1);
      wait_release(n);
      check_eq("loss_relatency", 32'(n + 2), 32'(LATENCY));
      $display("loss in run: re-release %0d edges after lock returned", n + 2);

      // Asynchronous reset while running (count is non-zero beforehand).
      step(1'b1);
      async_reset_pulse();
      wait_release(n);
      check_eq("post_async_latency", 32'(n), 32'(LATENCY));
      $display("async reset: release after %0d edges", n);

      // Saturation of the loss counter.
      for (int i = 0; i < 300; i++) begin
         step(1'b0);
         wait_release(n);
      end
      check_eq("saturated_count", 32'(lock_lost_count), 32'd255);
      $display("saturation: lock_lost_count=%0d after 300 losses", lock_lost_count);

      // Random lock glitches with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 3) async_reset_pulse();
         else step((r < 25) ? 1'b0 : 1'b1);
      end
      $display("random: 3000 cycles, count=%0d", lock_lost_count);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
